// File: rtl/iram_scanout_if.sv
// Scan-out bundle: LCD_CTRL start/busy, the IRAM synchronous read port and the panel pixel stream.
// The master modport is the scan-out engine; the slave modport is the surrounding system.
interface iram_scanout_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 6
) ();
  logic              start;
  logic              busy;
  logic              IRAM_rd;
  logic [ADDR_W-1:0] IRAM_A;
  logic [PIX_W-1:0]  IRAM_Q;
  logic [PIX_W-1:0]  px_data;
  logic              px_valid;
  logic              px_ready;
  logic              px_sol;
  logic              px_eol;
  logic              px_sof;
  logic              px_eof;

  modport master (
    input  start, IRAM_Q, px_ready,
    output busy, IRAM_rd, IRAM_A, px_data, px_valid, px_sol, px_eol, px_sof, px_eof
  );

  modport slave (
    output start, IRAM_Q, px_ready,
    input  busy, IRAM_rd, IRAM_A, px_data, px_valid, px_sol, px_eol, px_sof, px_eof
  );
endinterface

// File: rtl/iram_scanout.sv
// Reads an IMG_W x IMG_W frame from IRAM after start and streams it in raster order; first pixel 2 cycles after busy.
// Panel back-pressure is absorbed by a 2-entry buffer; reads pause while buffer + in-flight read reach 2.
module iram_scanout #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 8,
  parameter int ADDR_W = 6
) (
  input logic            clk,
  input logic            reset,
  iram_scanout_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam int                LINE_BITS = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] oc_q, oc_d;
  logic [PIX_W-1:0]  buf0_q, buf0_d;
  logic [PIX_W-1:0]  buf1_q, buf1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q, inflight_d;

  logic                 xfer;
  logic                 issue;
  logic [1:0]           occ;
  logic [LINE_BITS-1:0] line_pos;

  assign occ      = cnt_q + {1'b0, inflight_q};
  assign xfer     = (cnt_q != 2'd0) && bus.px_ready;
  // A transfer this cycle frees a slot, so a full pipeline may still issue.
  assign issue    = (state_q == FETCH) && ((occ < 2'd2) || ((occ == 2'd2) && xfer));
  assign line_pos = oc_q[LINE_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    oc_d       = oc_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;

    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d    = FETCH;
        addr_d     = '0;
        oc_d       = '0;
        buf0_d     = '0;
        buf1_d     = '0;
        cnt_d      = 2'd0;
        inflight_d = 1'b0;
      end
    end else begin
      inflight_d = issue;
      if (issue) begin
        if (addr_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      if (xfer) begin
        oc_d = oc_q + ADDR_W'(1);
        if (oc_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      // Returning read data lands one cycle after issue; occupancy bound keeps it from overflowing.
      case ({inflight_q, xfer})
        2'b01: begin
          buf0_d = buf1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            buf0_d = bus.IRAM_Q;
          end else begin
            buf1_d = bus.IRAM_Q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_d = bus.IRAM_Q;
          end else begin
            buf0_d = buf1_q;
            buf1_d = bus.IRAM_Q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      oc_q       <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      oc_q       <= oc_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.IRAM_rd  = issue;
  assign bus.IRAM_A   = addr_q;
  assign bus.px_valid = (cnt_q != 2'd0);
  assign bus.px_data  = bus.px_valid ? buf0_q : '0;
  assign bus.px_sol   = bus.px_valid && (line_pos == '0);
  assign bus.px_eol   = bus.px_valid && (line_pos == '1);
  assign bus.px_sof   = bus.px_valid && (oc_q == '0);
  assign bus.px_eof   = bus.px_valid && (oc_q == LAST_IDX);
endmodule

// File: doc/iram_scanout.md
# iram_scanout

Display scan-out stage downstream of LCD_CTRL. When LCD_CTRL finishes processing and pulses `done`, this block reads the 64-pixel 8x8 frame back from IRAM through a synchronous read port. It then streams the pixels in raster order to the LCD panel driver over a valid/ready handshake, with start/end-of-line and start/end-of-frame markers. A 2-entry buffer absorbs panel back-pressure without losing in-flight reads.

## Interface
- `PIX_W`, 8, pixel width in bits
- `IMG_W`, 8, pixels per line; frame is IMG_W x IMG_W
- `ADDR_W`, 6, IRAM address width; must satisfy 2^ADDR_W = IMG_W*IMG_W
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low; sampled on posedge clk
- `start`  in  1  one-cycle pulse, driven from LCD_CTRL `done`
- `IRAM_rd`  out  1  IRAM read enable
- `IRAM_A`  out  ADDR_W  IRAM read address
- `IRAM_Q`  in  PIX_W  IRAM read data, valid the cycle after `IRAM_rd`
- `px_data`  out  PIX_W  pixel to panel
- `px_valid`  out  1  `px_data` and markers valid
- `px_ready`  in  1  panel accepts; a transfer occurs when `px_valid & px_ready` at posedge
- `px_sol` / `px_eol`  out  1  first / last pixel of a line, qualified by `px_valid`
- `px_sof` / `px_eof`  out  1  pixel 0 / pixel 63 of the frame, qualified by `px_valid`
- `busy`  out  1  frame scan in progress

## Operation
- States:
  - IDLE: `start` -> FETCH; clear the read address, output counter, buffer and in-flight flag.
  - FETCH: issue reads until address 63 has been issued -> DRAIN.
  - DRAIN: wait for all buffered pixels to transfer. The 64th transfer -> IDLE.
- Read issue rule:
  - Issue a read in a cycle when (buffer count + in-flight) < 2, or == 2 with a transfer occurring that cycle.
  - Issue only in FETCH.
  - `IRAM_A` increments by 1 per issued read, 0..63. No wrap within a frame.
- In-flight read: `IRAM_Q` is written into the buffer at the posedge ending the cycle after issue. The buffer never overflows, so no read data is dropped.
- Buffer: 2-entry FIFO. The head drives `px_data`. `px_valid` = buffer not empty.
- Output counter `oc` (0..63) advances on each transfer. Markers:
  - `px_sol` = (oc mod IMG_W == 0)
  - `px_eol` = (oc mod IMG_W == IMG_W-1)
  - `px_sof` = (oc == 0)
  - `px_eof` = (oc == 63)
- `start` while `busy`=1: ignored. No restart, no queueing.
- `start` in the same cycle as the final transfer: ignored (`busy` is still 1).
- `px_ready` may toggle arbitrarily. `px_data`, `px_valid` and the markers stay stable while `px_valid & !px_ready`.
- Reset at any time, including mid-frame, aborts the scan. The next frame needs a new `start`.

## Timing
- Reset values, asserted the cycle after reset is sampled low:
  - `IRAM_rd`=0, `IRAM_A`=0
  - `px_valid`=0, `px_data`=0, all markers 0
  - `busy`=0, state IDLE, buffer empty, in-flight cleared
- Let `start` be sampled at the posedge ending cycle s:
  - `busy`=1 from cycle s+1.
  - First `IRAM_rd` (A=0) in cycle s+1.
  - First `px_valid` in cycle s+3.
- With `px_ready` held 1: one pixel per cycle in cycles s+3..s+66. Read addresses 0..63 are issued in cycles s+1..s+64.
- `busy` stays 1 through the cycle of the 64th transfer and is 0 the following cycle.
- `IRAM_rd`=0 in every cycle when no read is issued. `IRAM_A` holds its value when idle.
- Back-pressure: reads stop once (buffer + in-flight) = 2. Reads resume in the same cycle the next transfer occurs.

## Test plan
- Reset then idle: hold reset low 2 cycles, release, no `start` for 10 cycles -> `IRAM_rd`, `px_valid`, `busy` and all markers stay 0.
- Full-rate frame: IRAM preloaded with pattern `addr*3+1`, `px_ready`=1, `start` pulse -> 64 pixels 0x01,0x04,...,0xBE in cycles s+3..s+66.
  - `px_sof` on pixel 0 only; `px_eof` on pixel 63 only.
  - `px_sol` on pixels 0,8,...,56; `px_eol` on pixels 7,15,...,63.
  - `busy` low at s+67.
- Back-pressure: `px_ready` low for 5 cycles starting at s+4 -> at most 2 reads are outstanding, `px_data`=0x04 is held stable, no pixel is lost or duplicated, and all 64 pixels arrive in order.
- Random `px_ready` (50% duty) -> all 64 pixels arrive in order, markers are correct, and the cycle count equals the number of ready-high cycles needed.
- `start` re-pulsed at s+20 and again on the final-transfer cycle -> both pulses ignored, exactly 64 transfers, then idle.
- Reset asserted mid-frame at pixel 30 -> next cycle all outputs are at reset values. A new `start` produces a full frame beginning at address 0 with `px_sof`.
